uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; the frame format and divisor are latched at each frame start.
// Define UART_TX_CTS_EN to add a synchronised active-low cts_n input that gates frame starts.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        tx_en,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    input  logic                        two_stop,
    input  logic [DIV_W-1:0]            baud_div,
`ifdef UART_TX_CTS_EN
    input  logic                        cts_n,
`endif
    output logic                        tx_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full,
    output logic                        fifo_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic              push, pop, cts_ok, start_ok, bit_end;
    state_t            state, state_n;
    logic [DIV_W-1:0]  baud_cnt, baud_n, div_r;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              tx_n, par_en_r, two_stop_r, par_r;

    assign fifo_full  = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign fifo_empty = fifo_count == '0;
    assign wr_ready   = !fifo_full;
    assign push       = wr_valid && !fifo_full;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_s;
    // Reset to "not clear" so nothing starts before the line has been sampled.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cts_s <= 2'b11;
        else cts_s <= {cts_s[0], cts_n};
    assign cts_ok = !cts_s[1];
`else
    assign cts_ok = 1'b1;
`endif

    assign start_ok = !fifo_empty && tx_en && cts_ok;
    assign bit_end  = baud_cnt == div_r;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            div_r      <= '0;
            par_en_r   <= 1'b0;
            two_stop_r <= 1'b0;
            par_r      <= 1'b0;
            tx_out     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            tx_out   <= tx_n;
            if (pop) begin
                div_r      <= baud_div;
                par_en_r   <= parity_en;
                two_stop_r <= two_stop;
                par_r      <= ^mem[rd_ptr] ^ parity_odd;
            end
        end

    always_comb begin
        state_n = state;
        baud_n  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        tx_n    = tx_out;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                pop    = start_ok;
            end
            START: if (bit_end) begin
                state_n = DATA;
                tx_n    = shift[0];
                bit_n   = '0;
            end
            DATA: if (bit_end) begin
                if (bit_cnt == BW'(DATA_W-1)) begin
                    state_n = par_en_r ? PARITY : STOP;
                    tx_n    = par_en_r ? par_r : 1'b1;
                    bit_n   = '0;
                end else begin
                    shift_n = shift >> 1;
                    tx_n    = shift[1];
                    bit_n   = bit_cnt + 1'b1;
                end
            end
            PARITY: if (bit_end) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (bit_end) begin
                // bit_cnt counts stop bits here; a pending word chains straight into its start bit.
                if (two_stop_r && bit_cnt == '0) bit_n = BW'(1);
                else if (start_ok) pop = 1'b1;
                else state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            state_n = START;
            baud_n  = '0;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a queue-based frame waveform model.
module tb_uart_tx_fifo;
    logic        clk = 0, rst_n = 1, wr_valid = 0, tx_en = 0;
    logic        parity_en = 0, parity_odd = 0, two_stop = 0;
    logic [7:0]  wr_data = 0;
    logic [15:0] baud_div = 0;
    logic        wr_ready, tx_out, busy, fifo_full, fifo_empty;
    logic [3:0]  fifo_count;
    int          checks = 0, failures = 0;
    logic [7:0]  mq[$];
    logic        wave[$];
    logic [7:0]  w[9];

    uart_tx_fifo dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .tx_en(tx_en), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .baud_div(baud_div), .tx_out(tx_out), .busy(busy), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word queue plus the per-clock line levels still to be driven for the current frame.
    task automatic model_step();
        logic       st, pu;
        logic [7:0] d;
        logic       bits[$];
        st = wave.size() <= 1 && mq.size() > 0 && tx_en;
        pu = wr_valid && mq.size() < 8;
        if (wave.size() > 0) wave.delete(0);
        if (st) begin
            d = mq.pop_front();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(d[i]);
            if (parity_en) bits.push_back(^d ^ parity_odd);
            bits.push_back(1'b1);
            if (two_stop) bits.push_back(1'b1);
            foreach (bits[i])
                for (int c = 0; c <= int'(baud_div); c++) wave.push_back(bits[i]);
        end
        if (pu) mq.push_back(wr_data);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            wave.delete();
        end else model_step();
    end

    initial forever begin
        @(negedge clk);
        check("m_tx_out", int'(tx_out), wave.size() > 0 ? int'(wave[0]) : 1);
        check("m_busy", int'(busy), int'(wave.size() > 0));
        check("m_count", int'(fifo_count), mq.size());
        check("m_full", int'(fifo_full), int'(mq.size() == 8));
        check("m_empty", int'(fifo_empty), int'(mq.size() == 0));
        check("m_ready", int'(wr_ready), int'(mq.size() < 8));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1;
        wr_data  = d;
        tick();
        wr_valid = 0;
    endtask

    task automatic cfg(input logic [15:0] dv, input logic pe, input logic po, input logic ts);
        baud_div = dv;
        parity_en = pe;
        parity_odd = po;
        two_stop = ts;
    endtask

    task automatic frame_check(input string name, input logic [11:0] bits, input int nbits, input int per);
        for (int i = 0; i < nbits; i++)
            for (int c = 0; c < per; c++) begin
                check(name, int'(tx_out), int'(bits[i]));
                check({name, "_busy"}, int'(busy), 1);
                tick();
            end
    endtask

    initial begin
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", int'(tx_out), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_empty", int'(fifo_empty), 1);
        check("rst_full", int'(fifo_full), 0);
        check("rst_ready", int'(wr_ready), 1);
        rst_n = 1;
        tick();

        cfg(3, 0, 0, 0);
        tx_en = 1;
        push(8'h55);
        check("f55_pre_tx", int'(tx_out), 1);
        check("f55_pre_busy", int'(busy), 0);
        tick();
        frame_check("f55", 12'b00_1010101010, 10, 4);
        check("f55_end_busy", int'(busy), 0);

        cfg(3, 1, 1, 1);
        push(8'h03);
        tick();
        frame_check("f03_odd", 12'b111000000110, 12, 4);
        check("f03_odd_end", int'(busy), 0);
        cfg(3, 1, 0, 1);
        push(8'h03);
        tick();
        frame_check("f03_even", 12'b110000000110, 12, 4);
        check("f03_even_end", int'(busy), 0);

        cfg(3, 0, 0, 0);
        tx_en = 0;
        for (int i = 0; i < 9; i++) begin
            w[i] = 8'($urandom);
            push(w[i]);
            check("fill_count", int'(fifo_count), i < 8 ? i + 1 : 8);
            if (i == 7) check("ready_after_8", int'(wr_ready), 0);
        end
        check("fill_full", int'(fifo_full), 1);
        tx_en = 1;
        tick();
        for (int i = 0; i < 8; i++) frame_check("b2b", {3'b001, w[i], 1'b0}, 10, 4);
        check("b2b_end_busy", int'(busy), 0);
        check("b2b_end_empty", int'(fifo_empty), 1);

        cfg(0, 0, 0, 0);
        tx_en = 0;
        push(8'hA5);
        push(8'h0F);
        tx_en = 1;
        tick();
        baud_div = 7;
        frame_check("fa5_div0", 12'b00_1101001010, 10, 1);
        frame_check("f0f_div7", 12'b00_1000011110, 10, 8);
        check("div_end_busy", int'(busy), 0);

        cfg(3, 0, 0, 0);
        tx_en = 0;
        repeat (3) push(8'h00);
        tx_en = 1;
        tick();
        repeat (17) tick();
        check("mid_tx_low", int'(tx_out), 0);
        check("mid_count", int'(fifo_count), 2);
        rst_n = 0;
        #1;
        check("arst_tx", int'(tx_out), 1);
        check("arst_busy", int'(busy), 0);
        check("arst_count", int'(fifo_count), 0);
        tick();
        rst_n = 1;
        repeat (50) begin
            check("post_rst_tx", int'(tx_out), 1);
            check("post_rst_empty", int'(fifo_empty), 1);
            tick();
        end

        for (int n = 0; n < 3000; n++) begin
            wr_valid = ($urandom % 3) == 0;
            wr_data  = 8'($urandom);
            tx_en    = ($urandom % 8) != 0;
            if ($urandom % 40 == 0)
                cfg(16'($urandom % 4), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom % 900 == 0) rst_n = 0;
            tick();
            rst_n = 1;
        end
        wr_valid = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
